// File: rtl/lsu_axi_pkg.sv
// Shared types and constants for the LSU AXI4-Lite initiator.
// State encoding, access-size codes, response code, strobe helpers.
package lsu_axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        WR_RESP,
        DONE
    } state_t;

    localparam logic [1:0] SIZE_B    = 2'b00;
    localparam logic [1:0] SIZE_H    = 2'b01;
    localparam logic [1:0] SIZE_W    = 2'b10;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Strobe base masks for byte, half and word accesses.
    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    function automatic logic [3:0] strb_base(
        input logic [1:0] size
    );
        case (size)
            SIZE_B:  return STRB_B;
            SIZE_H:  return STRB_H;
            SIZE_W:  return STRB_W;
            default: return 4'b0000;
        endcase
    endfunction

    // Illegal size or an access not naturally aligned.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return off[0];
            SIZE_W:  return |off;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extraction: shifts the bus word down to the byte offset and
// sign/zero-extends it. Ports: i_rdata, i_off, i_size, i_uns -> o_data.
module lsu_load_ext
    import lsu_axi_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    output logic [31:0] o_data
);

    logic [31:0] w_sh;

    assign w_sh = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_data = 32'h0;
        case (i_size)
            SIZE_B: begin
                if (i_uns) o_data = {24'h0, w_sh[7:0]};
                else       o_data = {{24{w_sh[7]}}, w_sh[7:0]};
            end
            SIZE_H: begin
                if (i_uns) o_data = {16'h0, w_sh[15:0]};
                else       o_data = {{16{w_sh[15]}}, w_sh[15:0]};
            end
            SIZE_W:  o_data = w_sh;
            default: o_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_axi_master.sv
// AXI4-Lite initiator for the LSU: one load/store at a time, aligned
// store data/strobes, extended load data, one-cycle response pulse.
// Ports: clk, rst (async active-low), req_* from execute, resp_* back,
// m_ar*/m_r* read channels, m_aw*/m_w*/m_b* write channels.
module lsu_axi_master
    import lsu_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready
);

    state_t              r_state;
    logic [1:0]          r_off;
    logic [1:0]          r_size;
    logic                r_uns;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_bready;
    logic                r_aw_done;
    logic                r_w_done;
    logic                r_resp_valid;
    logic                r_resp_err;
    logic [DATA_W-1:0]   r_resp_rdata;

    logic [31:0] w_ld_data;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_aw_fin;
    logic        w_w_fin;

    lsu_load_ext u_ext (
        .i_rdata (m_rdata),
        .i_off   (r_off),
        .i_size  (r_size),
        .i_uns   (r_uns),
        .o_data  (w_ld_data)
    );

    assign w_aw_hs  = r_awvalid & m_awready;
    assign w_w_hs   = r_wvalid & m_wready;
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done | w_w_hs;

    // Held low during reset even though the state already reads IDLE.
    assign req_ready  = rst & (r_state == IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign m_araddr   = r_addr;
    assign m_awaddr   = r_addr;
    assign m_arvalid  = r_arvalid;
    assign m_rready   = r_rready;
    assign m_awvalid  = r_awvalid;
    assign m_wvalid   = r_wvalid;
    assign m_wdata    = r_wdata;
    assign m_wstrb    = r_wstrb;
    assign m_bready   = r_bready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_off        <= 2'b00;
            r_size       <= 2'b00;
            r_uns        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_off   <= req_addr[1:0];
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        r_wdata <= req_wdata << {req_addr[1:0], 3'b000};
                        r_wstrb <= strb_base(req_size) << req_addr[1:0];
                        if (misaligned(req_size, req_addr[1:0])) begin
                            r_state      <= DONE;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else if (req_wen) begin
                            r_state   <= WR;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                        end else begin
                            r_state   <= RD_ADDR;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    if (m_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_rvalid) begin
                        r_rready     <= 1'b0;
                        r_state      <= DONE;
                        r_resp_valid <= 1'b1;
                        if (m_rresp != RESP_OKAY) begin
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_resp_err   <= 1'b0;
                            r_resp_rdata <= w_ld_data;
                        end
                    end
                end
                WR: begin
                    // AW and W complete independently, in any order.
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_state  <= WR_RESP;
                        r_bready <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (m_bvalid) begin
                        r_bready     <= 1'b0;
                        r_state      <= DONE;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= (m_bresp != RESP_OKAY);
                        r_resp_rdata <= '0;
                    end
                end
                DONE: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_axi_master.md
# lsu_axi_master

AXI4-Lite initiator for the LSU. It accepts one load or store request at a time from the execute stage and issues the matching read (AR/R) or write (AW/W/B) transaction to the data-memory slave. It aligns store data and strobes, and extracts and sign/zero-extends load data. It returns a single-cycle response pulse to the core and is the master-side counterpart of the SRAM slave on the LSU bus.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 32; strobe width DATA_W/8)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  LSU request valid
- req_ready  out  1  block idle, can accept
- req_wen  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend load
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores/errors)
- resp_err  out  1  bus error or misaligned/illegal request
- m_araddr/m_arvalid/m_arready  out/out/in  32/1/1  read address
- m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  32/2/1/1  read data
- m_awaddr/m_awvalid/m_awready  out/out/in  32/1/1  write address
- m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  32/4/1/1  write data
- m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  write response

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE.
- IDLE: req_ready=1. On req_valid: latch addr, size, unsigned, wen, wdata.
  - size=11, or half with addr[0]=1, or word with addr[1:0]!=0 -> DONE, resp_err=1, no bus activity.
  - Otherwise, load -> RD_ADDR; store -> WR.
- Bus address = {addr[31:2],2'b00} on both channels.
- RD_ADDR: arvalid=1 until arready, then RD_DATA.
- RD_DATA: rready=1.
  - On rvalid: shift rdata right by 8*addr[1:0], then extend per size/unsigned.
  - rresp!=00 -> err=1, data=0. Go to DONE.
- WR: awvalid and wvalid both asserted on entry.
  - Each valid drops independently after its own handshake; tracked by aw_done/w_done flags.
  - Handshakes may occur in either order or in the same cycle.
  - When both are done -> WR_RESP.
- Store alignment: wdata = req_wdata << 8*addr[1:0]; wstrb = {0001,0011,1111}[size] << addr[1:0].
- WR_RESP: bready=1. On bvalid: err = (bresp!=00); go to DONE.
- DONE: resp_valid=1 for exactly one cycle, then IDLE.
- A valid, once asserted, is never deasserted before its ready. Address, data and strobe stay stable while valid is high.

## Timing
- Reset (rst=0, async): state IDLE; all m_*valid, m_rready, m_bready, resp_valid, resp_err = 0; resp_rdata=0; req_ready=0 while rst low, 1 in IDLE afterwards.
- All bus outputs and resp_* are registered. req_ready is decoded from state.
- Load, zero-wait slave: accept at cycle 0; arvalid cycles 1; rready cycle 2; rvalid at cycle 2 -> resp_valid cycle 3. Minimum latency 3 cycles.
- Store, zero-wait slave: aw/w handshake cycle 1; bready cycle 2; resp_valid cycle 3.
- Misaligned/illegal request: resp_valid on cycle 1, no valid ever raised.
- Reset mid-transaction aborts immediately; no completion pulse. Responses arriving after reset are ignored because ready is low.
- Back-to-back: the next request is accepted the cycle after resp_valid.

## Structure
- Package lsu_axi_pkg: state enum, SIZE_B/H/W codes, RESP_OKAY=2'b00, strobe base-mask constant.
- One sub-module: lsu_load_ext, combinational shift plus sign/zero extension of the load word (rdata, offset, size, unsigned -> 32-bit result).
- The FSM and the store alignment stay in the top module.

## Test plan
- Load byte: addr 0x80000003, signed; slave rdata 0x80FF_1234 -> araddr 0x80000000, resp_rdata 0xFFFF_FF80, resp_err=0, resp_valid at cycle 3.
- Load half unsigned: addr 0x80000002; rdata 0xBEEF_0000 -> resp_rdata 0x0000_BEEF.
- Store byte: addr 0x80000001, wdata 0x000000AB -> wdata 0x0000AB00, wstrb 0010. Slave asserts wready 2 cycles before awready -> resp_valid exactly once, after bvalid.
- Misaligned word load at 0x80000002 -> resp_err=1 on cycle 1, arvalid never high.
- Slave returns rresp=2'b10 -> resp_err=1, resp_rdata=0. Then bresp=OKAY on the next store -> resp_err=0.
- rst pulled low while in RD_DATA with arready already taken -> all outputs 0 asynchronously. After release, req_ready=1 and no stale resp_valid.
